// File: rtl/div16u_seq.sv
// Sequential unsigned restoring divider: DIVIDEND_W-bit dividend by DIVISOR_W-bit divisor,
// one quotient bit per cycle, valid/ready handshake on both the operand and result sides.
module div16u_seq #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIVIDEND_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_next;

  logic [DIVIDEND_W-1:0] dq_q;
  logic [DIVISOR_W-1:0]  dvs_q;
  logic [DIVISOR_W:0]    pr_q;
  logic [CNT_W-1:0]      cnt_q;

  logic                  accept;
  logic                  last_step;
  logic                  q_bit;
  logic [DIVISOR_W:0]    pr_shift;
  logic [DIVISOR_W+1:0]  trial;
  logic [DIVISOR_W:0]    pr_step;

  // pr_q[DIVISOR_W] is always zero after a step (remainder < divisor), so the
  // 10-bit subtraction below never wraps into a false "no borrow".
  always_comb begin
    pr_shift = {pr_q[DIVISOR_W-1:0], dq_q[DIVIDEND_W-1]};
    trial    = {pr_q, dq_q[DIVIDEND_W-1]} - {2'b00, dvs_q};
    q_bit    = ~trial[DIVISOR_W+1];
    pr_step  = q_bit ? trial[DIVISOR_W:0] : pr_shift;
  end

  assign accept    = in_valid && (state == IDLE);
  assign last_step = (state == CALC) && (cnt_q == LAST_STEP);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every signal driven here gets a value before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = (divisor == '0) ? DONE : CALC;
      end
      CALC: begin
        if (last_step) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      dq_q        <= '0;
      dvs_q       <= '0;
      pr_q        <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      dq_q  <= dividend;
      dvs_q <= divisor;
      pr_q  <= '0;
      cnt_q <= '0;
      if (divisor == '0) begin
        quotient    <= '1;
        remainder   <= dividend[DIVISOR_W-1:0];
        div_by_zero <= 1'b1;
      end
    end else if (state == CALC) begin
      dq_q  <= {dq_q[DIVIDEND_W-2:0], q_bit};
      pr_q  <= pr_step;
      cnt_q <= cnt_q + 1'b1;
      if (last_step) begin
        quotient    <= {dq_q[DIVIDEND_W-2:0], q_bit};
        remainder   <= pr_step[DIVISOR_W-1:0];
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div16u_seq.sv
// Self-checking bench for div16u_seq: directed cases with fixed expectations,
// backpressure, mid-operation reset and a randomised scoreboard regression.
module tb_div16u_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  always #5 clk = ~clk;

  div16u_seq dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 8'd0) begin
      e.q   = 16'hFFFF;
      e.r   = a[7:0];
      e.dbz = 1'b1;
    end else begin
      e.q   = a / {8'd0, b};
      e.r   = 8'(a % {8'd0, b});
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Starts one operation from a negedge; returns at the negedge after the accept edge.
  task automatic start_op(input logic [15:0] a, input logic [7:0] b, input exp_t e, output bit ok);
    int waits = 0;
    ok = 1'b0;
    while (!in_ready && waits < 50) begin
      @(posedge clk);
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      return;
    end
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    ok = 1'b1;
  endtask

  task automatic run_op(input logic [15:0] a, input logic [7:0] b, input exp_t e,
                        input int stall, input bit poke);
    exp_t got;
    int   edges = 0;
    bit   ok;
    start_op(a, b, e, ok);
    if (!ok) return;
    while (!out_valid && edges < 40) begin
      check("busy_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    check("latency", edges, (b == 8'd0) ? 32'd0 : 32'd16);
    if (!out_valid || sb.size() == 0) begin
      check("result_timeout", 32'd0, 32'd1);
      return;
    end
    got = sb.pop_front();
    check("quotient", 32'(quotient), 32'(got.q));
    check("remainder", 32'(remainder), 32'(got.r));
    check("div_by_zero", 32'(div_by_zero), 32'(got.dbz));
    if (b != 8'd0) begin
      check("inv_sum", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
      check("inv_rem_lt_div", 32'(remainder < b), 32'd1);
    end
    out_ready = 1'b0;
    repeat (stall) begin
      if (poke) begin
        in_valid = 1'b1;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_quotient", 32'(quotient), 32'(got.q));
      check("stall_remainder", 32'(remainder), 32'(got.r));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("post_out_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
    check("post_quotient", 32'(quotient), 32'(got.q));
    check("post_div_by_zero", 32'(div_by_zero), 32'(got.dbz));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_quotient"}, 32'(quotient), 32'd0);
    check({tag, "_remainder"}, 32'(remainder), 32'd0);
    check({tag, "_div_by_zero"}, 32'(div_by_zero), 32'd0);
  endtask

  function automatic exp_t fixed(input logic [15:0] a, input logic [7:0] b,
                                 input logic [15:0] q, input logic [7:0] r, input logic dbz);
    exp_t e;
    e.a = a;
    e.b = b;
    e.q = q;
    e.r = r;
    e.dbz = dbz;
    return e;
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0] ra;
  logic [7:0]  rb;
  int          sel;
  bit          ok;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("reset");

    run_op(16'd1000, 8'd7, fixed(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0), 0, 1'b0);
    run_op(16'd65535, 8'd1, fixed(16'd65535, 8'd1, 16'd65535, 8'd0, 1'b0), 1, 1'b0);
    run_op(16'd65535, 8'd255, fixed(16'd65535, 8'd255, 16'd257, 8'd0, 1'b0), 0, 1'b0);
    run_op(16'd5, 8'd200, fixed(16'd5, 8'd200, 16'd0, 8'd5, 1'b0), 2, 1'b0);
    run_op(16'h3039, 8'd0, fixed(16'h3039, 8'd0, 16'hFFFF, 8'h39, 1'b1), 0, 1'b0);

    // Backpressure with competing operands offered while the result is held.
    run_op(16'd54321, 8'd97, fixed(16'd54321, 8'd97, 16'd560, 8'd1, 1'b0), 10, 1'b1);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("no_stray_accept", 32'(out_valid), 32'd0);
    end

    // Reset after eight CALC iterations of 40000 / 3.
    start_op(16'd40000, 8'd3, fixed(16'd40000, 8'd3, 16'd13333, 8'd1, 1'b0), ok);
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    check_reset_state("midcalc_rst");
    run_op(16'd40000, 8'd3, fixed(16'd40000, 8'd3, 16'd13333, 8'd1, 1'b0), 0, 1'b0);

    // Reset while a divide-by-zero result waits in DONE.
    start_op(16'hBEEF, 8'd0, fixed(16'hBEEF, 8'd0, 16'hFFFF, 8'hEF, 1'b1), ok);
    check("done_before_rst", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    check_reset_state("done_rst");

    for (int i = 0; i < 2000; i++) begin
      ra  = 16'($urandom);
      sel = $urandom_range(0, 15);
      if (sel == 0)     rb = 8'd0;
      else if (sel < 5) rb = 8'($urandom_range(1, 15));
      else              rb = 8'($urandom_range(1, 255));
      if (sel == 1) ra = 16'($urandom_range(0, 300));
      run_op(ra, rb, model(ra, rb), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
